// File: rtl/phold_pkg.sv
// rtl/phold_pkg.sv - shared types, widths and saturating add for PHOLD cores
package phold_pkg;

    localparam int PHOLD_NIDB      = 3;
    localparam int PHOLD_NRB       = 8;
    localparam int PHOLD_TW        = 16;
    localparam int PHOLD_LOOKAHEAD = 1;
    localparam int PHOLD_EVT_CW    = 16;
    // Working width for timestamp arithmetic; timestamps up to 31 bits are supported.
    localparam int PHOLD_SAT_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WORK,
        ST_GEN,
        ST_EMIT,
        ST_DONE
    } phold_state_e;

    // Adds a and b with one guard bit and clamps the result to the largest w-bit value.
    function automatic logic [PHOLD_SAT_W-1:0] sat_add(
        input logic [PHOLD_SAT_W-1:0] a,
        input logic [PHOLD_SAT_W-1:0] b,
        input int                     w
    );
        logic [PHOLD_SAT_W:0] sum;
        logic [PHOLD_SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{PHOLD_SAT_W{1'b0}}, 1'b1} << w) - 1'b1;
        return (sum > lim) ? PHOLD_SAT_W'(lim) : PHOLD_SAT_W'(sum);
    endfunction

endpackage

// File: rtl/phold_delay_gen.sv
// rtl/phold_delay_gen.sv - combinational new-event timestamp with delay mode and saturation
module phold_delay_gen
    import phold_pkg::*;
#(
    parameter int NRB       = PHOLD_NRB,
    parameter int TW        = PHOLD_TW,
    parameter int LOOKAHEAD = PHOLD_LOOKAHEAD
) (
    input  logic [TW-1:0]  base_time,
    input  logic [NRB-1:0] random_in,
    input  logic           delay_mode,
    output logic [TW-1:0]  new_time
);

    logic [PHOLD_SAT_W-1:0] delta;

    // Increment is LOOKAHEAD plus the random delay (unless fixed mode); clamp rather than wrap.
    always_comb begin
        delta    = PHOLD_SAT_W'(LOOKAHEAD)
                 + (delay_mode ? {PHOLD_SAT_W{1'b0}} : PHOLD_SAT_W'(random_in));
        new_time = TW'(sat_add(PHOLD_SAT_W'(base_time), delta, TW));
    end

endmodule

// File: rtl/phold_core_fanout.sv
// rtl/phold_core_fanout.sv - PHOLD logical-process core with configurable event fanout
module phold_core_fanout
    import phold_pkg::*;
#(
    parameter int NIDB       = PHOLD_NIDB,
    parameter int NRB        = PHOLD_NRB,
    parameter int TW         = PHOLD_TW,
    parameter int MAX_FANOUT = 4,
    parameter int LOOKAHEAD  = PHOLD_LOOKAHEAD,
    parameter int PROC_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          event_valid,
    input  logic [NIDB-1:0]               event_id,
    input  logic [TW-1:0]                 event_time,
    input  logic [TW-1:0]                 global_time,
    input  logic [NRB-1:0]                random_in,
    input  logic [NIDB-1:0]               random_tgt,
    input  logic [$clog2(MAX_FANOUT):0]   fanout_cfg,
    input  logic                          delay_mode,
    output logic                          ready,
    output logic [TW-1:0]                 new_event_time,
    output logic [NIDB-1:0]               new_event_target,
    output logic                          new_event_ready,
    input  logic                          ack,
    output logic                          causality_err,
    output logic [PHOLD_EVT_CW-1:0]       evt_count
);

    localparam int FW = $clog2(MAX_FANOUT) + 1;
    localparam int CW = (PROC_LAT > 1) ? $clog2(PROC_LAT) : 1;

    phold_state_e           state_q, state_d;
    logic [NIDB-1:0]        lp_id_q, lp_id_d;
    logic [TW-1:0]          time_q, time_d;
    logic [FW-1:0]          fanout_q, fanout_d;
    logic [CW-1:0]          work_cnt_q, work_cnt_d;
    logic [FW-1:0]          emit_cnt_q, emit_cnt_d;
    logic [TW-1:0]          out_time_q, out_time_d;
    logic [NIDB-1:0]        out_tgt_q, out_tgt_d;
    logic                   out_rdy_q, out_rdy_d;
    logic                   ready_q, ready_d;
    logic                   cerr_q, cerr_d;
    logic [PHOLD_EVT_CW-1:0] evt_cnt_q, evt_cnt_d;

    logic [TW-1:0]          gen_time;
    logic [FW-1:0]          emit_next;
    logic [FW-1:0]          fanout_clamped;

    // The latched LP id is held for the event lifetime but no output consumes it yet.
    logic unused_lp_id;
    assign unused_lp_id = ^lp_id_q;

    phold_delay_gen #(
        .NRB       (NRB),
        .TW        (TW),
        .LOOKAHEAD (LOOKAHEAD)
    ) u_delay_gen (
        .base_time  (time_q),
        .random_in  (random_in),
        .delay_mode (delay_mode),
        .new_time   (gen_time)
    );

    assign emit_next      = emit_cnt_q + 1'b1;
    assign fanout_clamped = (fanout_cfg > FW'(MAX_FANOUT)) ? FW'(MAX_FANOUT) : fanout_cfg;

    // Next-state and next-output logic for the accept / work / generate / emit / done sequence.
    always_comb begin
        state_d    = state_q;
        lp_id_d    = lp_id_q;
        time_d     = time_q;
        fanout_d   = fanout_q;
        work_cnt_d = work_cnt_q;
        emit_cnt_d = emit_cnt_q;
        out_time_d = out_time_q;
        out_tgt_d  = out_tgt_q;
        out_rdy_d  = out_rdy_q;
        ready_d    = ready_q;
        cerr_d     = cerr_q;
        evt_cnt_d  = evt_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (event_valid) begin
                    lp_id_d    = event_id;
                    time_d     = event_time;
                    fanout_d   = fanout_clamped;
                    work_cnt_d = CW'(PROC_LAT - 1);
                    emit_cnt_d = '0;
                    ready_d    = 1'b0;
                    state_d    = ST_WORK;
                    if (event_time < global_time) begin
                        cerr_d = 1'b1;
                    end
                end
            end
            ST_WORK: begin
                if (work_cnt_q == '0) begin
                    state_d = (fanout_q == '0) ? ST_DONE : ST_GEN;
                end else begin
                    work_cnt_d = work_cnt_q - 1'b1;
                end
            end
            ST_GEN: begin
                out_time_d = gen_time;
                out_tgt_d  = random_tgt;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                // Outputs settle for one cycle before the valid flag is raised.
                if (!out_rdy_q) begin
                    out_rdy_d = 1'b1;
                end else if (ack) begin
                    out_rdy_d  = 1'b0;
                    emit_cnt_d = emit_next;
                    state_d    = (emit_next < fanout_q) ? ST_GEN : ST_DONE;
                end
            end
            ST_DONE: begin
                evt_cnt_d = evt_cnt_q + 1'b1;
                ready_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset drops any in-flight event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lp_id_q    <= '0;
            time_q     <= '0;
            fanout_q   <= '0;
            work_cnt_q <= '0;
            emit_cnt_q <= '0;
            out_time_q <= '0;
            out_tgt_q  <= '0;
            out_rdy_q  <= 1'b0;
            ready_q    <= 1'b1;
            cerr_q     <= 1'b0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lp_id_q    <= lp_id_d;
            time_q     <= time_d;
            fanout_q   <= fanout_d;
            work_cnt_q <= work_cnt_d;
            emit_cnt_q <= emit_cnt_d;
            out_time_q <= out_time_d;
            out_tgt_q  <= out_tgt_d;
            out_rdy_q  <= out_rdy_d;
            ready_q    <= ready_d;
            cerr_q     <= cerr_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign ready            = ready_q;
    assign new_event_time   = out_time_q;
    assign new_event_target = out_tgt_q;
    assign new_event_ready  = out_rdy_q;
    assign causality_err    = cerr_q;
    assign evt_count        = evt_cnt_q;

endmodule

// File: tb/tb_phold_core_fanout.sv
// tb/tb_phold_core_fanout.sv - scoreboard bench for phold_core_fanout
module tb_phold_core_fanout;

    localparam int NIDB       = 3;
    localparam int NRB        = 8;
    localparam int TW         = 16;
    localparam int MAX_FANOUT = 4;
    localparam int LOOKAHEAD  = 1;
    localparam int PROC_LAT   = 2;
    localparam int FW         = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            event_valid;
    logic [NIDB-1:0] event_id;
    logic [TW-1:0]   event_time;
    logic [TW-1:0]   global_time;
    logic [NRB-1:0]  random_in;
    logic [NIDB-1:0] random_tgt;
    logic [FW-1:0]   fanout_cfg;
    logic            delay_mode;
    logic            ready;
    logic [TW-1:0]   new_event_time;
    logic [NIDB-1:0] new_event_target;
    logic            new_event_ready;
    logic            ack;
    logic            causality_err;
    logic [15:0]     evt_count;

    always #5 clk = ~clk;

    phold_core_fanout #(
        .NIDB(NIDB), .NRB(NRB), .TW(TW), .MAX_FANOUT(MAX_FANOUT),
        .LOOKAHEAD(LOOKAHEAD), .PROC_LAT(PROC_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .event_valid(event_valid), .event_id(event_id),
        .event_time(event_time), .global_time(global_time), .random_in(random_in),
        .random_tgt(random_tgt), .fanout_cfg(fanout_cfg), .delay_mode(delay_mode),
        .ready(ready), .new_event_time(new_event_time), .new_event_target(new_event_target),
        .new_event_ready(new_event_ready), .ack(ack), .causality_err(causality_err),
        .evt_count(evt_count)
    );

    typedef struct {
        logic [TW-1:0]   t;
        logic [NIDB-1:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_count = 0;
    int   model_evt = 0;
    bit   model_cerr = 1'b0;

    function automatic logic [TW-1:0] model_ts(input logic [TW-1:0] t, input logic m, input logic [NRB-1:0] r);
        int s;
        s = int'(t) + LOOKAHEAD + (m ? 0 : int'(r));
        return (s > 65535) ? 16'hFFFF : TW'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected emission on every rising new_event_ready and checks it is held.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev  = 1'b0;
        e.t   = '0;
        e.tgt = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (new_event_ready && !prev) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_event: time=0x%0h target=%0d with none expected", new_event_time, new_event_target);
                    end else begin
                        e = exp_q.pop_front();
                        chk("emit_time", 32'(new_event_time), 32'(e.t));
                        chk("emit_target", 32'(new_event_target), 32'(e.tgt));
                    end
                end else if (new_event_ready) begin
                    chk("hold_time", 32'(new_event_time), 32'(e.t));
                    chk("hold_target", 32'(new_event_target), 32'(e.tgt));
                end
                prev = new_event_ready;
            end
        end
    end

    task automatic run_event(
        input logic [NIDB-1:0] id, input logic [TW-1:0] t, input logic [TW-1:0] gvt,
        input logic [FW-1:0] cfg, input logic mode, input bit use_fixed,
        input logic [31:0] fixed_r, input logic [11:0] fixed_g,
        input int stall_idx, input int stall_len
    );
        int nf;
        int lat;
        int hs0;
        int st;
        logic [NRB-1:0]  rv[MAX_FANOUT];
        logic [NIDB-1:0] gv[MAX_FANOUT];
        nf = (int'(cfg) > MAX_FANOUT) ? MAX_FANOUT : int'(cfg);
        for (int k = 0; k < MAX_FANOUT; k++) begin
            rv[k] = use_fixed ? fixed_r[8*k +: 8] : NRB'($urandom_range(0, 255));
            gv[k] = use_fixed ? fixed_g[3*k +: 3] : NIDB'($urandom_range(0, 7));
        end
        lat = 0;
        while (!ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ready_before_accept", 32'(ready), 32'd1);
        for (int k = 0; k < nf; k++) exp_q.push_back('{model_ts(t, mode, rv[k]), gv[k]});
        if (t < gvt) model_cerr = 1'b1;
        hs0         = hs_count;
        event_id    = id;
        event_time  = t;
        global_time = gvt;
        fanout_cfg  = cfg;
        delay_mode  = mode;
        random_in   = rv[0];
        random_tgt  = gv[0];
        event_valid = 1'b1;
        @(posedge clk); #1;
        // Late config change, lingering valid and a stray ack must all be ignored.
        fanout_cfg = FW'($urandom_range(0, 7));
        ack        = 1'b1;
        chk("ready_after_accept", 32'(ready), 32'd0);
        chk("causality_err", 32'(causality_err), 32'(model_cerr));
        if (nf == 0) begin
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
                if (lat == 1) begin event_valid = 1'b0; ack = 1'b0; end
            end while (!ready && lat < 50);
            chk("lat_zero_fanout", 32'(lat), 32'(PROC_LAT + 1));
        end else begin
            for (int k = 0; k < nf; k++) begin
                lat = 0;
                do begin
                    @(posedge clk); #1;
                    lat++;
                    if (lat == 1) begin event_valid = 1'b0; ack = 1'b0; end
                end while (!new_event_ready && lat < 50);
                if (k == 0) chk("lat_first_emit", 32'(lat), 32'(PROC_LAT + 2));
                else        chk("lat_next_emit", 32'(lat), 32'd2);
                st = (k == stall_idx) ? stall_len : int'($urandom_range(0, 2));
                repeat (st) begin @(posedge clk); #1; end
                chk("ready_held", 32'(new_event_ready), 32'd1);
                ack = 1'b1;
                @(posedge clk); #1;
                ack = 1'b0;
                if (k + 1 < nf) begin
                    random_in  = rv[k+1];
                    random_tgt = gv[k+1];
                end else begin
                    random_in  = NRB'($urandom_range(0, 255));
                    random_tgt = NIDB'($urandom_range(0, 7));
                end
                chk("ready_drop_on_ack", 32'(new_event_ready), 32'd0);
            end
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!ready && lat < 50);
            chk("lat_done", 32'(lat), 32'd1);
        end
        model_evt++;
        chk("evt_count", 32'(evt_count), 32'(model_evt & 16'hFFFF));
        chk("handshakes", 32'(hs_count - hs0), 32'(nf));
        chk("causality_sticky", 32'(causality_err), 32'(model_cerr));
        chk("no_emit_in_idle", 32'(new_event_ready), 32'd0);
    endtask

    // Stimulus: directed cases, randomized traffic, then an asynchronous reset during EMIT.
    initial begin : driver
        int lat;
        logic [TW-1:0] t;
        rst_n       = 1'b0;
        event_valid = 1'b0;
        event_id    = '0;
        event_time  = '0;
        global_time = '0;
        random_in   = '0;
        random_tgt  = '0;
        fanout_cfg  = '0;
        delay_mode  = 1'b0;
        ack         = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_new_event_ready", 32'(new_event_ready), 32'd0);
        chk("rst_new_event_time", 32'(new_event_time), 32'd0);
        chk("rst_new_event_target", 32'(new_event_target), 32'd0);
        chk("rst_causality_err", 32'(causality_err), 32'd0);
        chk("rst_evt_count", 32'(evt_count), 32'd0);

        run_event(3'd2, 16'd5, 16'd0, 3'd1, 1'b0, 1'b1, 32'h0000_001A, {3'd0, 3'd0, 3'd0, 3'd6}, -1, 0);
        run_event(3'd1, 16'd10, 16'd0, 3'd3, 1'b0, 1'b1, {8'd0, 8'd0, 8'd7, 8'd3}, {3'd0, 3'd5, 3'd1, 3'd2}, 1, 5);
        run_event(3'd4, 16'd15, 16'd0, 3'd1, 1'b1, 1'b0, 32'd0, 12'd0, -1, 0);
        run_event(3'd5, 16'd40, 16'd0, 3'd0, 1'b0, 1'b0, 32'd0, 12'd0, -1, 0);
        run_event(3'd6, 16'hFFF0, 16'd0, 3'd1, 1'b0, 1'b1, 32'h0000_00FF, 12'd3, -1, 0);
        run_event(3'd7, 16'd12, 16'd20, 3'd7, 1'b0, 1'b0, 32'd0, 12'd0, -1, 0);
        run_event(3'd0, 16'd30, 16'd20, 3'd2, 1'b0, 1'b0, 32'd0, 12'd0, -1, 0);

        for (int i = 0; i < 20; i++) begin
            t = TW'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) t = 16'hFF00 | TW'($urandom_range(0, 255));
            run_event(NIDB'($urandom_range(0, 7)), t, TW'($urandom_range(0, 65535)),
                      FW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 32'd0, 12'd0,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        // Reset while an emitted event is pending.
        lat = 0;
        while (!ready && lat < 50) begin @(posedge clk); #1; lat++; end
        exp_q.push_back('{model_ts(16'd100, 1'b0, 8'd9), 3'd3});
        event_time  = 16'd100;
        global_time = 16'd0;
        fanout_cfg  = 3'd2;
        delay_mode  = 1'b0;
        random_in   = 8'd9;
        random_tgt  = 3'd3;
        event_valid = 1'b1;
        @(posedge clk); #1;
        event_valid = 1'b0;
        lat = 0;
        while (!new_event_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("pre_reset_emit", 32'(new_event_ready), 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_new_event_ready", 32'(new_event_ready), 32'd0);
        chk("async_rst_evt_count", 32'(evt_count), 32'd0);
        chk("async_rst_causality_err", 32'(causality_err), 32'd0);
        exp_q.delete();
        model_evt  = 0;
        model_cerr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(ready), 32'd1);
        run_event(3'd2, 16'd50, 16'd10, 3'd2, 1'b0, 1'b0, 32'd0, 12'd0, -1, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phold_core_fanout.md
Name: phold_core_fanout

Overview:
- Parametrised successor to the PHOLD logical-process core.
- Accepts one event (LP id, timestamp) at a time and models processing work for a fixed number of cycles.
- Then emits a run-time-configurable number (0..MAX_FANOUT) of new events, one per ready/ack handshake, to the event queue / router.
- Adds selectable delay mode, timestamp saturation, causality checking and a processed-event counter.

Parameters:
- NIDB, 3, LP id / target width in bits.
- NRB, 8, random delay input width in bits.
- TW, 16, timestamp width in bits.
- MAX_FANOUT, 4, maximum new events per processed event.
- LOOKAHEAD, 1, minimum timestamp increment (TW bits).
- PROC_LAT, 2, work cycles per event; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- event_valid  in  1  incoming event strobe
- event_id  in  NIDB  incoming event LP id
- event_time  in  TW  incoming event timestamp
- global_time  in  TW  current GVT
- random_in  in  NRB  random delay, sampled per emitted event
- random_tgt  in  NIDB  random target, sampled per emitted event
- fanout_cfg  in  clog2(MAX_FANOUT)+1  new events per processed event
- delay_mode  in  1  0 = LOOKAHEAD+random_in; 1 = LOOKAHEAD only
- ready  out  1  core idle, can accept an event
- new_event_time  out  TW  emitted event timestamp
- new_event_target  out  NIDB  emitted event target LP
- new_event_ready  out  1  emitted event valid, held until ack
- ack  in  1  consumer accepted the emitted event
- causality_err  out  1  sticky: an event was accepted with event_time < global_time
- evt_count  out  16  processed-event counter, wraps at 0xFFFF

Behaviour:
- Reset (async, any state): state=IDLE. ready=1 once rst_n deasserts. All other outputs 0. Latched event, counters and causality_err cleared.
- States: IDLE, WORK, GEN, EMIT, DONE.
- IDLE, ready=1: event_valid sampled at a rising edge.
  - Latch event_id, event_time and fanout_cfg (clamped to MAX_FANOUT). Load the work counter with PROC_LAT-1. Go to WORK; ready=0 from that edge.
  - event_valid outside IDLE is ignored (no queueing).
- Causality check at acceptance: if event_time < global_time (unsigned), set causality_err. The event is still processed normally.
- WORK: decrement the counter; when it is 0, go to GEN, or to DONE if the latched fanout is 0.
- GEN (1 cycle): sample random_in and random_tgt.
  - Timestamp = event_time + LOOKAHEAD + (delay_mode ? 0 : random_in).
  - Add in TW+1 bits, then saturate to all-ones on overflow. Never wrap.
  - Target = random_tgt. Go to EMIT.
- EMIT:
  - new_event_ready=1; time and target outputs registered and stable until ack.
  - On an edge with ack=1: new_event_ready=0 from that edge. Increment the emitted count. Go to GEN if the count < fanout, else DONE.
  - ack while new_event_ready=0 is ignored.
- DONE (1 cycle): increment evt_count (wraps); go to IDLE, ready=1.
- Latency: new_event_ready first rises PROC_LAT+2 edges after the accept edge. Each subsequent emitted event rises 2 edges after the previous ack.
- fanout_cfg changes after acceptance have no effect on the current event.
- Reset mid-EMIT drops the pending event; no partial state survives.

Decomposition:
- Package phold_pkg:
  - state enum;
  - timestamp/id width constants;
  - a saturating-add helper function.
- Sub-module phold_delay_gen (combinational timestamp + delay-mode + saturation) is natural so other cores can reuse it.
- The FSM and handshake stay in phold_core_fanout.

Test Plan (NIDB=3, NRB=8, TW=16, LOOKAHEAD=1, PROC_LAT=2):
- Basic single: id=2, time=5, fanout_cfg=1, mode 0, random_in=0x1A, random_tgt=6 -> new_event_ready 4 edges after accept; time=32, target=6; ack -> ready=1 two edges later; evt_count=1.
- Fanout 3 with stall: time=10, random_in 3/7/0 per emission, ack delayed 5 cycles on the 2nd event -> three events 14, 18, 11; outputs stable during the stall; exactly 3 handshakes.
- Fixed mode and zero fanout: mode 1, time=15 -> emitted time=16 regardless of random_in. fanout_cfg=0 -> no new_event_ready; evt_count increments; ready returns after PROC_LAT+1 edges.
- Saturation: time=0xFFF0, random_in=0xFF, mode 0 -> new_event_time=0xFFFF.
- Causality and clamp: global_time=20, event_time=12 -> causality_err=1 and stays set through later legal events. fanout_cfg=7 with MAX_FANOUT=4 -> exactly 4 events.
- Reset mid-operation: assert rst_n=0 while in EMIT -> new_event_ready=0 immediately (async), evt_count=0, causality_err=0. After release ready=1, and a new event is processed normally.
